// File: rtl/audio_pwm_out_if.sv
// Link between the PWM audio output stage and its controller / waveform table.
// The controller side (master) drives the controls and the table sample; the PWM stage (slave) returns its status.
interface audio_pwm_out_if #(
  parameter int PHASE_W = 16
);
  logic               enable;
  logic               mute;
  logic [PHASE_W-1:0] step;
  logic [7:0]         sample_in;
  logic [7:0]         index;
  logic               pwm_out;
  logic               sample_strobe;
  logic               busy;

  modport master (
    output enable, mute, step, sample_in,
    input  index, pwm_out, sample_strobe, busy
  );

  modport slave (
    input  enable, mute, step, sample_in,
    output index, pwm_out, sample_strobe, busy
  );
endinterface

// File: rtl/audio_pwm_out.sv
// PWM audio output: a phase accumulator addresses the waveform table, and one
// returned sample per PWM period is latched as the duty cycle for the next period.
//
// state | meaning
// IDLE  | stopped; prescaler and PWM counter held at 0, output low
// RUN   | playing; sample latched and phase advanced at every period boundary
// STOP  | finishing the current period after enable dropped
module audio_pwm_out #(
  parameter int CLK_DIV = 1,
  parameter int PHASE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  audio_pwm_out_if.slave   bus
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t             state;
  logic [PRE_W-1:0]   pre_cnt;
  logic [7:0]         pwm_cnt;
  logic [7:0]         duty;
  logic [PHASE_W-1:0] phase;
  logic [7:0]         index_q;
  logic               pwm_q;
  logic               strobe_q;

  logic               tick;
  logic               boundary;
  logic [PHASE_W-1:0] phase_nxt;
  logic [7:0]         duty_nxt;

  assign tick      = (state != IDLE) && (pre_cnt == PRE_LAST);
  assign boundary  = tick && (pwm_cnt == 8'hFF);
  assign phase_nxt = phase + bus.step;
  assign duty_nxt  = bus.mute ? 8'h00 : bus.sample_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pre_cnt  <= '0;
      pwm_cnt  <= 8'h00;
      duty     <= 8'h00;
      phase    <= '0;
      index_q  <= 8'h00;
      pwm_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state)
        IDLE: begin
          pre_cnt <= '0;
          pwm_cnt <= 8'h00;
          pwm_q   <= 1'b0;
          if (bus.enable) begin
            state    <= RUN;
            duty     <= duty_nxt;
            strobe_q <= 1'b1;
          end
        end
        RUN, STOP: begin
          pwm_q <= (pwm_cnt < duty);
          if (tick) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
          end
          // A boundary in STOP with enable back high is treated exactly like RUN.
          if (boundary && (state == RUN || bus.enable)) begin
            duty     <= duty_nxt;
            phase    <= phase_nxt;
            index_q  <= phase_nxt[PHASE_W-1 -: 8];
            strobe_q <= 1'b1;
            state    <= bus.enable ? RUN : STOP;
          end else if (boundary) begin
            state <= IDLE;
            duty  <= 8'h00;
          end else begin
            state <= bus.enable ? RUN : STOP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.index         = index_q;
  assign bus.pwm_out       = pwm_q;
  assign bus.sample_strobe = strobe_q;
  assign bus.busy          = (state != IDLE);

endmodule

// File: doc/audio_pwm_out.md
Name: audio_pwm_out

Overview:
- Downstream consumer of the combinational waveform-table stage (8-bit index in, 8-bit sample out).
- Drives the table's index from a phase accumulator, so `step` sets the tone frequency.
- Latches one returned sample per PWM period and produces a 1-bit PWM stream for the board audio pin.
- Contains the only timing in the audio path: prescaler, PWM counter, phase accumulator and a run/stop FSM.

Parameters:
- CLK_DIV, 1, clk cycles per PWM tick (≥1); PWM period = 256*CLK_DIV clk cycles.
- PHASE_W, 16, phase accumulator width (≥9); index = phase[PHASE_W-1 -: 8].

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  start/continue playback; deassert for a graceful stop.
- mute  in  1  when 1, duty latched as 0 at each period boundary.
- step  in  PHASE_W  phase increment per PWM period.
- sample_in  in  8  sample from the waveform table for the current index.
- index  out  8  registered table address.
- pwm_out  out  1  registered PWM output.
- sample_strobe  out  1  one-cycle pulse when a sample is latched.
- busy  out  1  1 in RUN or STOP.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE; prescaler, pwm_cnt, phase and duty = 0.
  - index=0, pwm_out=0, sample_strobe=0, busy=0.
  - Applies immediately, including mid-period.
- tick:
  - Prescaler counts 0..CLK_DIV-1 in RUN/STOP; tick=1 on the cycle it equals CLK_DIV-1, then it wraps to 0.
  - With CLK_DIV=1, tick is high every cycle.
- pwm_cnt (8 bit): increments on tick, wraps 255->0. A period boundary is a tick with pwm_cnt==255.
- pwm_out: registered, equals (pwm_cnt < duty) evaluated each cycle in RUN/STOP.
  - duty=0: never high.
  - duty=255: high 255 of 256 ticks.
- FSM states: IDLE, RUN, STOP.
- IDLE:
  - Prescaler and pwm_cnt held at 0; pwm_out=0; phase/index hold their value.
  - On enable=1: next state RUN; on that same edge duty <= (mute ? 0 : sample_in), sample_strobe=1.
- RUN, at each period boundary:
  - duty <= (mute ? 0 : sample_in).
  - phase <= phase + step (modulo 2^PHASE_W, carry discarded).
  - index <= upper 8 bits of the new phase.
  - sample_strobe=1 for that cycle.
- RUN, enable=0 sampled on any cycle: next state STOP.
- STOP:
  - Completes the current period unchanged.
  - At the period boundary, if enable=0: state IDLE, duty<=0, no phase advance, no strobe.
  - If enable returns to 1 during STOP: back to RUN with no gap; the boundary is handled as in RUN.
- Latency:
  - index changes 1 cycle after a boundary.
  - The table output for that index is latched at the next boundary.
  - Audible sample therefore lags index by exactly one PWM period.
- Simultaneous events:
  - enable falling on a boundary cycle: RUN boundary actions occur, then state=STOP (a full extra period plays).
  - mute changes take effect only at a boundary.
  - step is sampled only at a boundary.
- busy = (state != IDLE).

Test Plan:
- Reset, CLK_DIV=1, step=0x0100, sample_in looped from index, enable=1 -> index steps 0,1,2,… every 256 cycles; sample_strobe exactly once per 256 cycles; high count of period k equals k-1 (period 0 = 0 highs).
- Duty extremes: sample_in fixed 0x00 -> pwm_out never high; 0xFF -> 255 highs then 1 low per period; 0x80 -> exactly 128 highs.
- Wrap and fractional step: phase preloaded to 0xFF00 by running, step=0x0100 -> index 0xFF then 0x00. step=0x0080 -> index advances every 2 periods.
- Graceful stop: drop enable at pwm_cnt=100 -> pwm continues to cnt 255, then busy=0, pwm_out=0, index unchanged. Re-raise enable at cnt 200 during STOP -> no gap and busy stays 1.
- Mute: mute=1 mid-period with sample 0xC0 -> current period keeps 192 highs, subsequent periods 0 highs; index still advancing.
- Async reset at pwm_cnt=50 with pwm_out=1 -> all outputs 0 within the same cycle without a clock edge. After release with enable=1, index restarts from 0.
